// File: rtl/pipe_datapath.sv
// pipe_datapath: ID -> EX -> MEM integer pipeline with a register file and a data memory.
// Ports: clk; rst_n (async, active low); instr_valid / instr_ready / instruccion
//   {opcode, WA, RA1, RA2} handshake; DATAOUT + dataout_valid (last load data);
//   retire (one pulse per committed instruction).
// Build option: define PIPE_DATAPATH_FWD_EN for EX/MEM operand forwarding;
//   without it, any RAW dependence on an in-flight producer stalls until commit.
module pipe_datapath #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int MEM_AW = 8,
    parameter int OPC_W  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          instr_valid,
    output logic                          instr_ready,
    input  logic [OPC_W+3*REG_AW-1:0]     instruccion,
    output logic [DATA_W-1:0]             DATAOUT,
    output logic                          dataout_valid,
    output logic                          retire
);

    localparam int IW    = OPC_W + 3 * REG_AW;
    localparam int NREG  = 2 ** REG_AW;
    localparam int NWORD = 2 ** MEM_AW;
    localparam int SH_W  = $clog2(DATA_W);

    typedef enum logic [3:0] {
        K_NOP, K_ADD, K_SUB, K_AND, K_OR, K_XOR,
        K_SLT, K_SHL, K_SHR, K_STORE, K_LOAD
    } kind_e;

    // ---------------- ID ----------------
    logic [OPC_W-1:0]  id_opc;
    logic [REG_AW-1:0] id_wa;
    logic [REG_AW-1:0] id_ra1;
    logic [REG_AW-1:0] id_ra2;
    kind_e             id_kind;
    logic              id_ld;
    logic              id_st;
    logic              id_alu;
    logic              id_use1;
    logic              id_use2;
    logic              id_we;

    assign id_opc = instruccion[IW-1 -: OPC_W];
    assign id_wa  = instruccion[3*REG_AW-1 -: REG_AW];
    assign id_ra1 = instruccion[2*REG_AW-1 -: REG_AW];
    assign id_ra2 = instruccion[REG_AW-1:0];

    always_comb begin
        id_kind = K_NOP;
        case (id_opc)
            OPC_W'(1):  id_kind = K_ADD;
            OPC_W'(2):  id_kind = K_SUB;
            OPC_W'(3):  id_kind = K_AND;
            OPC_W'(4):  id_kind = K_OR;
            OPC_W'(5):  id_kind = K_XOR;
            OPC_W'(6):  id_kind = K_SLT;
            OPC_W'(7):  id_kind = K_SHL;
            OPC_W'(8):  id_kind = K_SHR;
            OPC_W'(9):  id_kind = K_STORE;
            OPC_W'(10): id_kind = K_LOAD;
            default:    id_kind = K_NOP;
        endcase
    end

    assign id_ld   = (id_kind == K_LOAD);
    assign id_st   = (id_kind == K_STORE);
    assign id_alu  = (id_kind != K_NOP) && !id_ld && !id_st;
    assign id_use1 = (id_kind != K_NOP);
    assign id_use2 = id_alu || id_st;
    // Writes to R0 are dropped here, so R0 never becomes a producer.
    assign id_we   = (id_alu || id_ld) && (id_wa != '0);

    // ---------------- pipeline state ----------------
    logic              ex_valid;
    kind_e             ex_kind;
    logic              ex_we;
    logic [REG_AW-1:0] ex_wa;
    logic [DATA_W-1:0] ex_a;
    logic [DATA_W-1:0] ex_b;
    logic [DATA_W-1:0] ex_res;
    logic              ex_ld;

    logic              mem_valid;
    logic              mem_we;
    logic              mem_ld;
    logic              mem_st;
    logic [REG_AW-1:0] mem_wa;
    logic [DATA_W-1:0] mem_res;
    logic [DATA_W-1:0] mem_sd;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] dmem_rd;
    logic [DATA_W-1:0] mem_wb;

    logic [DATA_W-1:0] regs [0:NREG-1];
    logic [DATA_W-1:0] dmem [0:NWORD-1];

    // ---------------- operand select / hazards ----------------
    logic              ex_hit1;
    logic              ex_hit2;
    logic              mem_hit1;
    logic              mem_hit2;
    logic [DATA_W-1:0] rf1;
    logic [DATA_W-1:0] rf2;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic              stall;
    logic              accept;

    assign ex_hit1  = ex_valid && ex_we && (ex_wa == id_ra1);
    assign ex_hit2  = ex_valid && ex_we && (ex_wa == id_ra2);
    assign mem_hit1 = mem_valid && mem_we && (mem_wa == id_ra1);
    assign mem_hit2 = mem_valid && mem_we && (mem_wa == id_ra2);

    assign rf1 = (id_ra1 == '0) ? '0 : regs[id_ra1];
    assign rf2 = (id_ra2 == '0) ? '0 : regs[id_ra2];

    always_comb begin
`ifdef PIPE_DATAPATH_FWD_EN
        op1   = ex_hit1 ? ex_res : (mem_hit1 ? mem_wb : rf1);
        op2   = ex_hit2 ? ex_res : (mem_hit2 ? mem_wb : rf2);
        // Load data only exists in MEM, so a load in EX costs one bubble.
        stall = ex_ld && ((id_use1 && ex_hit1) || (id_use2 && ex_hit2));
`else
        op1   = rf1;
        op2   = rf2;
        stall = (id_use1 && (ex_hit1 || mem_hit1))
             || (id_use2 && (ex_hit2 || mem_hit2));
`endif
    end

    assign instr_ready = !stall;
    assign accept      = instr_valid && instr_ready;

    // ---------------- ID -> EX ----------------
    // NOP-class opcodes enter as bubbles: no commit, no retire, no forwarding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ex_kind  <= K_NOP;
            ex_we    <= 1'b0;
            ex_wa    <= '0;
            ex_a     <= '0;
            ex_b     <= '0;
        end else begin
            ex_valid <= accept && (id_kind != K_NOP);
            ex_kind  <= id_kind;
            ex_we    <= id_we;
            ex_wa    <= id_wa;
            ex_a     <= op1;
            ex_b     <= op2;
        end
    end

    // ---------------- EX ----------------
    assign ex_ld = ex_valid && (ex_kind == K_LOAD);

    always_comb begin
        ex_res = ex_a;
        case (ex_kind)
            K_ADD:   ex_res = ex_a + ex_b;
            K_SUB:   ex_res = ex_a - ex_b;
            K_AND:   ex_res = ex_a & ex_b;
            K_OR:    ex_res = ex_a | ex_b;
            K_XOR:   ex_res = ex_a ^ ex_b;
            K_SLT:   ex_res = {{(DATA_W-1){1'b0}},
                               ($signed(ex_a) < $signed(ex_b))};
            K_SHL:   ex_res = ex_a << ex_b[SH_W-1:0];
            K_SHR:   ex_res = ex_a >> ex_b[SH_W-1:0];
            default: ex_res = ex_a;
        endcase
    end

    // ---------------- EX -> MEM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_ld    <= 1'b0;
            mem_st    <= 1'b0;
            mem_wa    <= '0;
            mem_res   <= '0;
            mem_sd    <= '0;
        end else begin
            mem_valid <= ex_valid;
            mem_we    <= ex_we;
            mem_ld    <= (ex_kind == K_LOAD);
            mem_st    <= (ex_kind == K_STORE);
            mem_wa    <= ex_wa;
            mem_res   <= ex_res;
            mem_sd    <= ex_b;
        end
    end

    // ---------------- MEM / commit ----------------
    assign mem_addr = mem_res[MEM_AW-1:0];
    assign dmem_rd  = dmem[mem_addr];
    assign mem_wb   = mem_ld ? dmem_rd : mem_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            DATAOUT       <= '0;
            dataout_valid <= 1'b0;
            retire        <= 1'b0;
        end else begin
            if (mem_valid && mem_we) begin
                regs[mem_wa] <= mem_wb;
            end
            if (mem_valid && mem_ld) begin
                DATAOUT <= dmem_rd;
            end
            dataout_valid <= mem_valid && mem_ld;
            retire        <= mem_valid;
        end
    end

    // Memory contents survive reset; mem_valid is cleared asynchronously,
    // so an in-flight store is dropped.
    always_ff @(posedge clk) begin
        if (mem_valid && mem_st) begin
            dmem[mem_addr] <= mem_sd;
        end
    end

endmodule

// File: tb/tb_pipe_datapath.sv
// tb_pipe_datapath: directed vectors for pipe_datapath with a DATAOUT scoreboard.
// Registers are observed by storing them to mem[0] and loading back to DATAOUT.
module tb_pipe_datapath;

    localparam int DW = 32;
    localparam int RAW = 5;
    localparam int MAW = 8;
    localparam int OW = 4;
    localparam int IW = OW + 3 * RAW;

`ifdef PIPE_DATAPATH_FWD_EN
    localparam int RAW_ST = 0;
    localparam int LU_ST  = 1;
`else
    localparam int RAW_ST = 2;
    localparam int LU_ST  = 2;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          instr_valid = 1'b0;
    logic          instr_ready;
    logic [IW-1:0] instruccion = '0;
    logic [DW-1:0] DATAOUT;
    logic          dataout_valid;
    logic          retire;

    always #5 clk = ~clk;

    pipe_datapath #(
        .DATA_W(DW), .REG_AW(RAW), .MEM_AW(MAW), .OPC_W(OW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instruccion(instruccion),
        .DATAOUT(DATAOUT),
        .dataout_valid(dataout_valid),
        .retire(retire)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    int          ret_seen = 0;
    int          ret_exp = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];

    function automatic void check(string nm, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endfunction

    task automatic summary();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    endtask

    // Monitor: pops the scoreboard whenever DATAOUT is announced.
    always @(negedge clk) begin
        if (rst_n && retire) ret_seen++;
        if (rst_n && dataout_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL dataout_extra: got %h expected no load", DATAOUT);
            end else begin
                check(name_q.pop_front(), DATAOUT, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        n_vec++;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        summary();
        $finish;
    end

    function automatic logic [IW-1:0] enc(int op, int wa, int ra1, int ra2);
        logic [IW-1:0] r;
        r = {op[OW-1:0], wa[RAW-1:0], ra1[RAW-1:0], ra2[RAW-1:0]};
        return r;
    endfunction

    // Called at posedge+1; returns at posedge+1 after acceptance.
    task automatic issue(input int op, wa, ra1, ra2, output int stalls);
        stalls = 0;
        instr_valid = 1'b1;
        instruccion = enc(op, wa, ra1, ra2);
        forever begin
            @(negedge clk);
            if (instr_ready) break;
            stalls++;
            if (stalls > 20) begin
                n_vec++;
                n_bad++;
                $display("FAIL ready_timeout: got instr_ready=0 expected 1");
                summary();
                $finish;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        if (op >= 1 && op <= 10) ret_exp++;
    endtask

    task automatic op3(input int op, wa, ra1, ra2);
        int s;
        issue(op, wa, ra1, ra2, s);
    endtask

    task automatic ld(input int wa, ra1, input logic [31:0] exp, input string nm);
        int s;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        issue(10, wa, ra1, 0, s);
    endtask

    task automatic peek(input int r, input logic [31:0] exp, input string nm);
        op3(9, 0, 0, r);
        ld(31, 0, exp, nm);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int s1, s2, r0;

    initial begin
        dut.dmem[0]   <= 32'd5;
        dut.dmem[3]   <= 32'd0;
        dut.dmem[5]   <= 32'd7;
        dut.dmem[7]   <= 32'd9;
        dut.dmem[9]   <= 32'h103;
        dut.dmem[12]  <= 32'hFF;
        dut.dmem[18]  <= 32'hDEADBEEF;

        repeat (2) @(negedge clk);
        check("rst_dataout", DATAOUT, 32'd0);
        check("rst_dvalid", 32'(dataout_valid), 32'd0);
        check("rst_retire", 32'(retire), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(instr_ready), 32'd1);
        @(posedge clk);
        #1;

        // First load: latency of the DATAOUT pulse.
        ld(1, 0, 32'd5, "load_r1");
        @(negedge clk);
        check("lat_e0", 32'(dataout_valid), 32'd0);
        @(negedge clk);
        check("lat_e1", 32'(dataout_valid), 32'd0);
        @(negedge clk);
        check("lat_e2", 32'(dataout_valid), 32'd1);
        check("lat_retire", 32'(retire), 32'd1);
        @(negedge clk);
        check("lat_pulse", 32'(dataout_valid), 32'd0);
        @(posedge clk);
        #1;
        peek(1, 32'd5, "r1");

        // Back-to-back RAW on ALU results.
        ld(2, 1, 32'd7, "load_r2");
        idle(3);
        issue(1, 3, 1, 2, s1);
        issue(2, 4, 3, 1, s2);
        check("add_stall", s1, 0);
        check("sub_stall", s2, RAW_ST);
        peek(3, 32'd12, "r3_add");
        peek(4, 32'd7, "r4_sub");

        // Load-use.
        ld(5, 2, 32'd9, "load_r5");
        issue(1, 6, 5, 5, s1);
        check("lu_stall", s1, LU_ST);
        peek(6, 32'd18, "r6_lu");

        // R0 is never a producer.
        issue(1, 0, 1, 2, s1);
        issue(4, 7, 0, 0, s2);
        check("r0_stall", s2, 0);
        peek(7, 32'd0, "r7_or");
        peek(0, 32'd0, "r0");

        op3(5, 13, 1, 2);
        op3(6, 14, 1, 2);
        op3(2, 15, 0, 1);
        op3(6, 16, 15, 1);
        op3(6, 17, 1, 15);

        // Store above memory range, load wrapped address.
        ld(8, 5, 32'h103, "load_r8");
        ld(9, 6, 32'hDEADBEEF, "load_r9");
        ld(10, 3, 32'hFF, "load_r10");
        op3(3, 11, 8, 10);
        op3(9, 0, 8, 9);
        ld(12, 11, 32'hDEADBEEF, "store_wrap");

        op3(7, 18, 1, 11);
        op3(8, 19, 15, 11);
        op3(7, 20, 1, 8);
        op3(15, 21, 1, 2);
        op3(0, 22, 1, 2);

        peek(13, 32'd2, "xor");
        peek(14, 32'd1, "slt_pos");
        peek(15, 32'hFFFFFFFB, "sub_neg");
        peek(16, 32'd1, "slt_neg");
        peek(17, 32'd0, "slt_false");
        peek(18, 32'd40, "shl");
        peek(20, 32'd40, "shl_mask");
        peek(21, 32'd0, "op15_nop");
        peek(22, 32'd0, "op0_nop");
        peek(19, 32'h1FFFFFFF, "shr");
        idle(8);
        check("sb_empty", exp_q.size(), 0);
        check("retire_count", ret_seen, ret_exp);

        // Reset with three instructions in flight.
        r0 = ret_seen;
        op3(9, 0, 0, 2);
        op3(1, 22, 1, 2);
        ret_exp -= 2;
        instr_valid = 1'b1;
        instruccion = enc(10, 23, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst2_dataout", DATAOUT, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst2_no_retire", ret_seen, r0);
        ld(23, 0, 32'h1FFFFFFF, "mem_kept");
        peek(1, 32'd0, "rst2_r1");
        peek(19, 32'd0, "rst2_r19");
        peek(22, 32'd0, "rst2_r22");
        idle(8);
        check("sb_empty2", exp_q.size(), 0);
        check("retire_count2", ret_seen, ret_exp);

        summary();
        $finish;
    end

endmodule
